// File: rtl/layer_stream_gen.sv
`default_nettype none
// ============================================================================
// Module   : layer_stream_gen
// Purpose  : AXI4-Stream frame source. A rising edge on i_load_state starts
//            one fixed-length frame for the selected layer. Each word carries
//            the layer tag and its index within the frame.
// Revision : 1.0  initial release
// ============================================================================
module layer_stream_gen #(
    parameter int LEN0 = 16,
    parameter int LEN1 = 32,
    parameter int LEN2 = 64,
    parameter int LEN3 = 128
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_load_state,
    input  logic [1:0]  i_current_layer,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_frame_cnt
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]  state;
    logic        load_q;
    logic [1:0]  layer_r;
    logic [15:0] index;
    logic [15:0] len_r;
    logic [15:0] frame_cnt;
    logic [15:0] len_sel;
    logic        start;
    logic        handshake;
    logic        is_last;

    assign start     = i_load_state & ~load_q;
    assign handshake = (state == STREAM) & m_axis_tready;
    assign is_last   = (index == (len_r - 16'd1));

    // Frame length for the layer currently requested by the control block
    always_comb begin
        len_sel = 16'(LEN0);
        case (i_current_layer)
            2'd0:    len_sel = 16'(LEN0);
            2'd1:    len_sel = 16'(LEN1);
            2'd2:    len_sel = 16'(LEN2);
            2'd3:    len_sel = 16'(LEN3);
            default: len_sel = 16'(LEN0);
        endcase
    end

    // Edge detector history; updates in every state so busy-time edges are dropped
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            load_q <= 1'b0;
        end else begin
            load_q <= i_load_state;
        end
    end

    // Frame sequencer: latch layer/length on start, walk the index on handshakes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            layer_r <= 2'd0;
            index   <= 16'd0;
            len_r   <= 16'd1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= STREAM;
                        layer_r <= i_current_layer;
                        index   <= 16'd0;
                        len_r   <= len_sel;
                    end
                end
                STREAM: begin
                    if (handshake) begin
                        if (is_last) begin
                            state <= DONE;
                        end else begin
                            index <= index + 16'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Completed-frame counter, bumped on the final handshake (entry to DONE)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt <= 16'd0;
        end else if (handshake && is_last) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Outputs come straight from registered state so tvalid never sees tready
    assign m_axis_tvalid = (state == STREAM);
    assign m_axis_tlast  = m_axis_tvalid & is_last;
    assign m_axis_tdata  = {layer_r, 14'd0, index};
    assign o_busy        = (state != IDLE);
    assign o_done        = (state == DONE);
    assign o_frame_cnt   = frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_layer_stream_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_stream_gen
// Purpose  : Self-checking bench for layer_stream_gen against a frame-level
//            reference model (expected word = layer tag | index, per-layer
//            frame length table, frame counter).
// Revision : 1.0  initial release
// ============================================================================
module tb_layer_stream_gen;

    logic        clk;
    logic        rstn;
    logic        i_load_state;
    logic [1:0]  i_current_layer;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_frame_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_hs_cyc = 0;
    int exp_frames  = 0;

    layer_stream_gen #(
        .LEN0(16), .LEN1(32), .LEN2(64), .LEN3(128)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .i_load_state   (i_load_state),
        .i_current_layer(i_current_layer),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_frame_cnt    (o_frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: step past the edge so every sample/drive happens mid-cycle
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int frame_len(input logic [1:0] layer);
        int lens[4] = '{16, 32, 64, 128};
        return lens[layer];
    endfunction

    function automatic logic [31:0] exp_word(input logic [1:0] layer, input int idx);
        return (32'(layer) << 30) | 32'(idx);
    endfunction

    // Raise load for one cycle; the first beat must be visible right after the edge
    task automatic start_frame(input logic [1:0] layer);
        i_current_layer = layer;
        i_load_state    = 1'b1;
        m_axis_tready   = 1'b0;
        tick();
        check_eq("start_tvalid", 32'(m_axis_tvalid), 32'd1);
        i_load_state = 1'b0;
    endtask

    // Stream a whole frame, comparing every cycle against the model.
    // ready_pct: percent chance tready is high; poke: disturb load/layer mid-frame.
    task automatic stream_frame(input logic [1:0] layer, input int ready_pct,
                                input bit poke, input int stop_after);
        int len = frame_len(layer);
        int idx = 0;
        int n   = 0;
        bit hs;
        while (idx < len && n < 4000 && !(stop_after >= 0 && idx == stop_after)) begin
            check_eq("tvalid", 32'(m_axis_tvalid), 32'd1);
            check_eq("tdata", m_axis_tdata, exp_word(layer, idx));
            check_eq("tlast", 32'(m_axis_tlast), 32'(idx == len - 1));
            check_eq("busy", 32'(o_busy), 32'd1);
            if (poke) begin
                if (n == 10) i_load_state = 1'b0;
                if (n == 20) begin
                    i_load_state    = 1'b1;
                    i_current_layer = 2'd1;
                end
            end
            m_axis_tready = ($urandom_range(99) < ready_pct) ? 1'b1 : 1'b0;
            hs = m_axis_tready;
            tick();
            n++;
            if (hs) begin
                idx++;
                last_hs_cyc = cyc;
            end
        end
        m_axis_tready = 1'b0;
        if (n >= 4000) check_eq("frame_timeout", 32'd1, 32'd0);
        if (stop_after < 0) begin
            exp_frames = (exp_frames + 1) % 65536;
            check_eq("end_tvalid", 32'(m_axis_tvalid), 32'd0);
            check_eq("end_tlast", 32'(m_axis_tlast), 32'd0);
            check_eq("done_pulse", 32'(o_done), 32'd1);
            check_eq("done_busy", 32'(o_busy), 32'd1);
            check_eq("frame_cnt", 32'(o_frame_cnt), 32'(exp_frames));
            tick();
            check_eq("post_done", 32'(o_done), 32'd0);
            check_eq("post_busy", 32'(o_busy), 32'd0);
            check_eq("post_tvalid", 32'(m_axis_tvalid), 32'd0);
        end
    endtask

    // Watch for a number of cycles with no frame expected
    task automatic expect_quiet(input int cycles, input bit all_zero);
        for (int i = 0; i < cycles; i++) begin
            check_eq("quiet_tvalid", 32'(m_axis_tvalid), 32'd0);
            check_eq("quiet_busy", 32'(o_busy), 32'd0);
            check_eq("quiet_done", 32'(o_done), 32'd0);
            if (all_zero) begin
                check_eq("quiet_tdata", m_axis_tdata, 32'd0);
                check_eq("quiet_tlast", 32'(m_axis_tlast), 32'd0);
                check_eq("quiet_cnt", 32'(o_frame_cnt), 32'd0);
            end
            tick();
        end
    endtask

    initial begin
        rstn            = 1'b0;
        i_load_state    = 1'b0;
        i_current_layer = 2'd0;
        m_axis_tready   = 1'b0;

        // Reset and idle
        repeat (3) tick();
        rstn = 1'b1;
        expect_quiet(20, 1'b1);

        // Basic frame, layer 1, tready held high
        start_frame(2'd1);
        stream_frame(2'd1, 100, 1'b0, -1);
        expect_quiet(3, 1'b0);

        // Backpressure on layer 0
        start_frame(2'd0);
        stream_frame(2'd0, 50, 1'b0, -1);
        expect_quiet(3, 1'b0);

        // Load dropped and re-raised mid-frame on layer 3: must be ignored
        start_frame(2'd3);
        stream_frame(2'd3, 80, 1'b1, -1);
        expect_quiet(5, 1'b0);
        check_eq("ignored_cnt", 32'(o_frame_cnt), 32'(exp_frames));
        i_load_state = 1'b0;
        tick();

        // Back-to-back: restart in the idle cycle right after the done pulse.
        // The edge cannot be taken during DONE, so the gap from the last
        // handshake to the next first beat is the DONE cycle plus the IDLE
        // cycle in which the edge is sampled: two clock edges.
        start_frame(2'd2);
        stream_frame(2'd2, 100, 1'b0, -1);
        start_frame(2'd2);
        check_eq("b2b_gap", 32'(cyc - last_hs_cyc), 32'd2);
        check_eq("b2b_first", m_axis_tdata, 32'h8000_0000);
        stream_frame(2'd2, 100, 1'b0, -1);

        // Reset mid-frame after beat 5 of layer 2
        tick();
        start_frame(2'd2);
        stream_frame(2'd2, 100, 1'b0, 5);
        check_eq("pre_rst_tdata", m_axis_tdata, 32'h8000_0005);
        #2;
        rstn = 1'b0;
        #1;
        exp_frames = 0;
        check_eq("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_cnt", 32'(o_frame_cnt), 32'd0);
        check_eq("rst_tdata", m_axis_tdata, 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        start_frame(2'd2);
        check_eq("restart_idx0", m_axis_tdata, 32'h8000_0000);
        stream_frame(2'd2, 70, 1'b0, -1);

        // Load already high at reset release counts as an edge
        rstn = 1'b0;
        exp_frames = 0;
        i_current_layer = 2'd0;
        i_load_state = 1'b1;
        tick();
        rstn = 1'b1;
        tick();
        check_eq("rel_start", 32'(m_axis_tvalid), 32'd1);
        i_load_state = 1'b0;
        stream_frame(2'd0, 100, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
